// File: rtl/regs_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regs_wb_arbiter_if
//   Bundle of writeback requester signals shared by REQ_N requesters and the
//   regfile write-port arbiter.
//   req_valid_i  REQ_N         requester i has a write pending
//   req_ready_o  REQ_N         one-hot grant from the arbiter
//   req_rd_i     REQ_N*ADDR_W  dest index, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata_i  REQ_N*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regs_wb_arbiter_if #(
  parameter int REQ_N  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [REQ_N-1:0]        req_valid_i;
  logic [REQ_N-1:0]        req_ready_o;
  logic [REQ_N*ADDR_W-1:0] req_rd_i;
  logic [REQ_N*DATA_W-1:0] req_wdata_i;

  modport master (
    output req_valid_i,
    output req_rd_i,
    output req_wdata_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_rd_i,
    input  req_wdata_i,
    output req_ready_o
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wb_arbiter
//   Shares the single register-file write port between REQ_N writeback
//   requesters. Round-robin grant on a valid/ready handshake; the winner is
//   registered into one write stage that drives the regfile port the next
//   cycle. Writes to x0 are accepted but never issued. Read-after-write hits
//   against the staged write are flagged for the decoder bypass.
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     hold_i              1 = grant nobody this cycle
//     req_if (slave)      requester valid/ready/rd/wdata bundle
//     wen_o/rd_o/wdata_o  registered regfile write port
//     rs1_i/rs2_i         decoder read indices
//     fwd1_hit_o/fwd2_hit_o  staged-write hit on rs1/rs2 (combinational)
//     wr_cnt_o            committed non-x0 write count (wraps)
// ---------------------------------------------------------------------------
module regs_wb_arbiter #(
  parameter int REQ_N  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hold_i,
  regs_wb_arbiter_if.slave    req_if,
  output logic                wen_o,
  output logic [ADDR_W-1:0]   rd_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic [ADDR_W-1:0]   rs1_i,
  input  logic [ADDR_W-1:0]   rs2_i,
  output logic                fwd1_hit_o,
  output logic                fwd2_hit_o,
  output logic [31:0]         wr_cnt_o
);

  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int CND_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQ_N - 1);

  // Per-requester views of the packed buses.
  logic [ADDR_W-1:0] rd_arr   [REQ_N];
  logic [DATA_W-1:0] data_arr [REQ_N];

  generate
    for (genvar gi = 0; gi < REQ_N; gi++) begin : g_unpack
      assign rd_arr[gi]   = req_if.req_rd_i[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_if.req_wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State
  logic [PTR_W-1:0]  ptr_q,   ptr_d;
  logic              wen_q,   wen_d;
  logic [ADDR_W-1:0] rd_q,    rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       cnt_q,   cnt_d;

  // Arbitration
  logic [REQ_N-1:0]  ready;
  logic [PTR_W-1:0]  win_idx;
  logic [CND_W-1:0]  cand;
  logic              hs;

  // Scan requesters starting at ptr_q, wrapping; first valid one wins.
  // Reset and hold both suppress the grant so no handshake can occur.
  always_comb begin
    ready   = '0;
    win_idx = '0;
    cand    = '0;
    hs      = 1'b0;
    if (!rst_i && !hold_i) begin
      for (int k = 0; k < REQ_N; k++) begin
        cand = {1'b0, ptr_q} + CND_W'(k);
        if (cand >= CND_W'(REQ_N)) begin
          cand = cand - CND_W'(REQ_N);
        end
        if (!hs && req_if.req_valid_i[cand[PTR_W-1:0]]) begin
          hs      = 1'b1;
          win_idx = cand[PTR_W-1:0];
        end
      end
      if (hs) begin
        ready[win_idx] = 1'b1;
      end
    end
  end

  assign req_if.req_ready_o = ready;

  // Write stage / pointer next state.
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  logic              commit;

  always_comb begin
    win_rd   = rd_arr[win_idx];
    win_data = data_arr[win_idx];
    // An x0 handshake is consumed but leaves the write port idle.
    commit   = hs && (win_rd != '0);
    wen_d    = commit;
    rd_d     = commit ? win_rd   : rd_q;
    wdata_d  = commit ? win_data : wdata_q;
    cnt_d    = commit ? cnt_q + 32'd1 : cnt_q;
    ptr_d    = ptr_q;
    if (hs) begin
      ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wen_o      = wen_q;
  assign rd_o       = rd_q;
  assign wdata_o    = wdata_q;
  assign wr_cnt_o   = cnt_q;
  // Gated by wen_q so a held (stale) rd_o never produces a bypass.
  assign fwd1_hit_o = wen_q && (rd_q == rs1_i);
  assign fwd2_hit_o = wen_q && (rd_q == rs2_i);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regs_wb_arbiter
//   Directed self-checking bench for regs_wb_arbiter (REQ_N=3, ADDR_W=5,
//   DATA_W=32). Inputs change 1 time unit after a rising edge; grants are
//   checked before the next edge and registered outputs 1 unit after it.
// ---------------------------------------------------------------------------
module tb_regs_wb_arbiter;
  logic        clk;
  logic        rst;
  logic        hold;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        fwd1;
  logic        fwd2;
  logic [31:0] wr_cnt;

  int total = 0;
  int bad   = 0;

  regs_wb_arbiter_if #(.REQ_N(3), .ADDR_W(5), .DATA_W(32)) bus_if ();

  regs_wb_arbiter #(.REQ_N(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .hold_i     (hold),
    .req_if     (bus_if),
    .wen_o      (wen),
    .rd_o       (rd),
    .wdata_o    (wdata),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .fwd1_hit_o (fwd1),
    .fwd2_hit_o (fwd2),
    .wr_cnt_o   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] r,
                         input logic [31:0] d);
    bus_if.req_valid_i[i]          = v;
    bus_if.req_rd_i[i*5 +: 5]      = r;
    bus_if.req_wdata_i[i*32 +: 32] = d;
  endtask

  task automatic clear_reqs;
    bus_if.req_valid_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b000) begin
      bad++; $display("FAIL reset_ready_comb: got %b want 000", bus_if.req_ready_o);
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      total++;
      if (wen !== 1'b0 || wr_cnt !== 32'd0) begin
        bad++; $display("FAIL reset_state: wen=%b cnt=%0d want wen=0 cnt=0", wen, wr_cnt);
      end
      total++;
      if (bus_if.req_ready_o !== 3'b000) begin
        bad++; $display("FAIL reset_ready: got %b want 000", bus_if.req_ready_o);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b001) begin
      bad++; $display("FAIL reset_first_grant: got %b want 001", bus_if.req_ready_o);
    end
    clear_reqs;
    $display("reset: done");
  endtask

  task automatic test_single;
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b010) begin
      bad++; $display("FAIL single_ready: got %b want 010", bus_if.req_ready_o);
    end
    tick;
    clear_reqs;
    total++;
    if (wen !== 1'b1 || rd !== 5'd5 || wdata !== 32'hDEADBEEF || wr_cnt !== 32'd1) begin
      bad++;
      $display("FAIL single_write: wen=%b rd=%0d wdata=%h cnt=%0d want 1/5/deadbeef/1",
               wen, rd, wdata, wr_cnt);
    end
    $display("single: req1 rd=%0d wdata=%h", rd, wdata);
  endtask

  task automatic test_fairness;
    logic [2:0] exp_ready;
    logic [4:0] exp_rd;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'hA1);
    set_req(1, 1'b1, 5'd2, 32'hA2);
    set_req(2, 1'b1, 5'd3, 32'hA3);
    for (int c = 0; c < 6; c++) begin
      case (c % 3)
        0:       begin exp_ready = 3'b001; exp_rd = 5'd1; end
        1:       begin exp_ready = 3'b010; exp_rd = 5'd2; end
        default: begin exp_ready = 3'b100; exp_rd = 5'd3; end
      endcase
      #1;
      total++;
      if (bus_if.req_ready_o !== exp_ready) begin
        bad++; $display("FAIL fair_grant[%0d]: got %b want %b", c, bus_if.req_ready_o, exp_ready);
      end
      tick;
      total++;
      if (wen !== 1'b1 || rd !== exp_rd || wdata !== {27'd0, 5'h0} + 32'hA0 + 32'(exp_rd)) begin
        bad++;
        $display("FAIL fair_write[%0d]: wen=%b rd=%0d wdata=%h want 1/%0d/%h",
                 c, wen, rd, wdata, exp_rd, 32'hA0 + 32'(exp_rd));
      end
      $display("fair: cycle %0d granted rd=%0d", c, rd);
    end
    clear_reqs;
    total++;
    if (wr_cnt !== 32'd6) begin
      bad++; $display("FAIL fair_count: got %0d want 6", wr_cnt);
    end
  endtask

  task automatic test_x0;
    set_req(0, 1'b1, 5'd0, 32'h1234);
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b001) begin
      bad++; $display("FAIL x0_ready: got %b want 001", bus_if.req_ready_o);
    end
    tick;
    clear_reqs;
    total++;
    if (wen !== 1'b0 || wr_cnt !== 32'd6 || rd !== 5'd3 || wdata !== 32'hA3) begin
      bad++;
      $display("FAIL x0_nowrite: wen=%b cnt=%0d rd=%0d wdata=%h want 0/6/3/a3",
               wen, wr_cnt, rd, wdata);
    end
    // Pointer must now be at 1: with 0 and 1 both valid, 1 wins.
    set_req(0, 1'b1, 5'd0, 32'h1234);
    set_req(1, 1'b1, 5'd4, 32'h44);
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b010) begin
      bad++; $display("FAIL x0_ptr_adv: got %b want 010", bus_if.req_ready_o);
    end
    tick;
    clear_reqs;
    total++;
    if (wen !== 1'b1 || rd !== 5'd4 || wdata !== 32'h44 || wr_cnt !== 32'd7) begin
      bad++;
      $display("FAIL x0_followup: wen=%b rd=%0d wdata=%h cnt=%0d want 1/4/44/7",
               wen, rd, wdata, wr_cnt);
    end
    $display("x0: accepted without write, then rd=%0d", rd);
  endtask

  task automatic test_hold_bypass;
    hold = 1'b1;
    set_req(2, 1'b1, 5'd7, 32'h77);
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b000) begin
      bad++; $display("FAIL hold_ready: got %b want 000", bus_if.req_ready_o);
    end
    tick;
    total++;
    if (wen !== 1'b0) begin
      bad++; $display("FAIL hold_wen: got %b want 0", wen);
    end
    hold = 1'b0;
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b100) begin
      bad++; $display("FAIL release_ready: got %b want 100", bus_if.req_ready_o);
    end
    tick;
    clear_reqs;
    rs1 = 5'd7;
    rs2 = 5'd7;
    #1;
    total++;
    if (wen !== 1'b1 || rd !== 5'd7 || wr_cnt !== 32'd8) begin
      bad++; $display("FAIL release_write: wen=%b rd=%0d cnt=%0d want 1/7/8", wen, rd, wr_cnt);
    end
    total++;
    if (fwd1 !== 1'b1 || fwd2 !== 1'b1) begin
      bad++; $display("FAIL fwd_both: fwd1=%b fwd2=%b want 1/1", fwd1, fwd2);
    end
    rs1 = 5'd8;
    #1;
    total++;
    if (fwd1 !== 1'b0 || fwd2 !== 1'b1) begin
      bad++; $display("FAIL fwd_miss: fwd1=%b fwd2=%b want 0/1", fwd1, fwd2);
    end
    tick;
    total++;
    if (wen !== 1'b0 || fwd2 !== 1'b0) begin
      bad++; $display("FAIL fwd_stale: wen=%b fwd2=%b want 0/0", wen, fwd2);
    end
    $display("hold/bypass: rd=%0d forwarded", rd);
  endtask

  task automatic test_reset_midop;
    set_req(0, 1'b1, 5'd9, 32'h99);
    #1;
    total++;
    if (bus_if.req_ready_o !== 3'b001) begin
      bad++; $display("FAIL midop_ready: got %b want 001", bus_if.req_ready_o);
    end
    tick;
    clear_reqs;
    total++;
    if (wen !== 1'b1 || rd !== 5'd9 || wr_cnt !== 32'd9) begin
      bad++; $display("FAIL midop_staged: wen=%b rd=%0d cnt=%0d want 1/9/9", wen, rd, wr_cnt);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if (wen !== 1'b0 || rd !== 5'd0 || wdata !== 32'd0 || wr_cnt !== 32'd0) begin
      bad++;
      $display("FAIL midop_reset: wen=%b rd=%0d wdata=%h cnt=%0d want 0/0/0/0",
               wen, rd, wdata, wr_cnt);
    end
    $display("reset mid-op: staged write discarded");
  endtask

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    rs1  = 5'd0;
    rs2  = 5'd0;
    bus_if.req_valid_i = '0;
    bus_if.req_rd_i    = '0;
    bus_if.req_wdata_i = '0;
    tick;
    test_reset;
    test_single;
    test_fairness;
    test_x0;
    test_hold_bypass;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
